// File: rtl/lp_issue_scheduler.sv
// lp_issue_scheduler: buffers fetched opcodes in a small FIFO and issues one
// per cycle to the low-power control unit. Memory-class opcodes stall while
// memory is busy, NOPs are dropped, and a power FSM gates the control unit's
// clock enable after a programmable idle period and sequences wake-up.
module lp_issue_scheduler #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned IDLE_THRESH = 8,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [2:0]  in_opcode,
    output logic        in_ready,
    input  logic        mem_busy,
    input  logic        sleep_en,
    output logic        issue_valid,
    output logic [2:0]  issue_opcode,
    output logic        cu_clk_en,
    output logic [1:0]  pwr_state,
    output logic [15:0] issued_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW = (IDLE_THRESH > 1) ? $clog2(IDLE_THRESH) : 1;
    localparam int unsigned WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_THRESH - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'b00,
        ST_SLEEP  = 2'b01,
        ST_WAKE   = 2'b10
    } pwr_t;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [2:0]    r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;

    // Power FSM and registered outputs
    pwr_t          r_state;
    logic [IW-1:0] r_idle_cnt;
    logic [WW-1:0] r_wake_cnt;
    logic          r_cu_clk_en;
    logic          r_issue_valid;
    logic [2:0]    r_issue_opcode;
    logic [15:0]   r_issued_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_idle;
    logic [2:0]    w_head;
    logic          w_head_nop;
    logic          w_head_mem;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push     = in_valid && !w_full;
    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign w_head_nop = (w_head == 3'b000);
    assign w_head_mem = (w_head == 3'b101) || (w_head == 3'b110);
    // Pops only happen in ACTIVE; a stalled memory opcode stays at the head.
    assign w_pop      = (r_state == ST_ACTIVE) && !w_empty &&
                        !(w_head_mem && mem_busy);
    assign w_issue    = w_pop && !w_head_nop;
    assign w_idle     = w_empty && !in_valid;

    assign in_ready     = !w_full;
    assign issue_valid  = r_issue_valid;
    assign issue_opcode = r_issue_opcode;
    assign cu_clk_en    = r_cu_clk_en;
    assign pwr_state    = r_state;
    assign issued_cnt   = r_issued_cnt;

    // FIFO data write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wptr[AW-1:0]] <= in_opcode;
        end
    end

    // FIFO pointer update on push and pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Issue outputs, issue counter and power FSM with registered clock enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_ACTIVE;
            r_idle_cnt     <= '0;
            r_wake_cnt     <= '0;
            r_cu_clk_en    <= 1'b1;
            r_issue_valid  <= 1'b0;
            r_issue_opcode <= 3'b000;
            r_issued_cnt   <= '0;
        end else begin
            r_issue_valid <= w_issue;
            if (w_issue) begin
                r_issue_opcode <= w_head;
                if (r_issued_cnt != 16'hFFFF) begin
                    r_issued_cnt <= r_issued_cnt + 16'd1;
                end
            end

            case (r_state)
                ST_ACTIVE: begin
                    r_cu_clk_en <= 1'b1;
                    if (w_idle) begin
                        if (sleep_en && (r_idle_cnt == IDLE_LAST)) begin
                            r_state     <= ST_SLEEP;
                            r_cu_clk_en <= 1'b0;
                            r_idle_cnt  <= '0;
                        end else if (r_idle_cnt != IDLE_LAST) begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end else begin
                        r_idle_cnt <= '0;
                    end
                end
                ST_SLEEP: begin
                    r_cu_clk_en <= 1'b0;
                    if (in_valid || !w_empty) begin
                        r_state     <= ST_WAKE;
                        r_cu_clk_en <= 1'b1;
                        r_wake_cnt  <= '0;
                    end
                end
                ST_WAKE: begin
                    r_cu_clk_en <= 1'b1;
                    if (r_wake_cnt == WAKE_LAST) begin
                        r_state    <= ST_ACTIVE;
                        r_wake_cnt <= '0;
                    end else begin
                        r_wake_cnt <= r_wake_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_ACTIVE;
                    r_cu_clk_en <= 1'b1;
                    r_idle_cnt  <= '0;
                    r_wake_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
